data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single data-memory port between the CPU datapath and an external
//  host (loader/debugger) for word read/write. CPU has priority. A starvation
//  counter forces host service and stalls the CPU (freezes PC) during host
//  access. Drives the datapath's hold/address-select and memory write enable.
// PARAMETERS
//  ADDR_W    10  data-memory word address width
//  DATA_W    32  data word width
//  MAX_WAIT   8  IDLE cycles a pending host request may lose to CPU before forced grant
//  WAIT_W     4  width of wait counter; must hold MAX_WAIT
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst         in   1       asynchronous reset, active-low
//  cpu_en      in   1       CPU memory access this cycle (memRead|memWrite)
//  cpu_we      in   1       CPU write strobe
//  cpu_addr    in   ADDR_W  CPU word address (ALU result)
//  cpu_wdata   in   DATA_W  CPU store data
//  cpu_stall   out  1       freeze PC / suppress regfile write
//  host_req    in   1       host request; addr/we/wdata stable until host_gnt
//  host_we     in   1       1 = write, 0 = read
//  host_addr   in   ADDR_W  host word address
//  host_wdata  in   DATA_W  host write data
//  host_gnt    out  1       one-cycle grant pulse
//  host_rdata  out  DATA_W  registered read data, held until next read
//  host_rvalid out  1       one-cycle pulse: host_rdata valid
//  hold        out  1       1 = memory port owned by host
//  mem_addr    out  ADDR_W  memory address
//  mem_we      out  1       memory write enable
//  mem_din     out  DATA_W  memory write data
//  mem_dout    in   DATA_W  memory read data, valid cycle after address presented
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, wait_cnt=0, host_rdata=0; all outputs 0.
//   Reset mid-access aborts it: mem_we drops immediately, no gnt/rvalid follows.
//  States: IDLE, H_ACC, H_WAIT.
//  IDLE: hold=0, mem_addr=cpu_addr, mem_din=cpu_wdata, mem_we=cpu_en&cpu_we,
//   cpu_stall=0. Go to H_ACC when host_req && (!cpu_en || wait_cnt==MAX_WAIT);
//   on that edge latch host_addr/host_we/host_wdata, clear wait_cnt.
//  wait_cnt (IDLE only): +1 per cycle with host_req&&cpu_en, saturates at
//   MAX_WAIT; cleared when host_req=0 or on grant.
//  H_ACC (1 cycle): host_gnt=1, hold=1, cpu_stall=1, mem_addr/mem_din = latched
//   host values, mem_we=latched we. Write -> IDLE; read -> H_WAIT.
//  H_WAIT (1 cycle): hold=1, cpu_stall=1, mem_we=0, address held; host_rdata
//   captures mem_dout at end of cycle; -> IDLE; host_rvalid=1 next cycle.
//  Latency: gnt one cycle after request accepted in IDLE; rvalid 2 cycles after gnt.
//  cpu_stall = (state!=IDLE) regardless of cpu_en; CPU access during stall is
//   ignored and re-presented by the stalled CPU.
//  Fairness: every host access returns to IDLE >=1 cycle; CPU never stalled on
//   consecutive host accesses without an unstalled cycle between.
//  host_req dropped before gnt: request is lost, no gnt, wait_cnt clears.
//  Outputs are combinational from state and latched regs; no input-to-gnt path.
// TESTING
//  T1 reset: rst=0 mid-traffic -> cpu_stall,hold,mem_we,host_gnt,host_rvalid=0, host_rdata=0.
//  T2 host write, cpu_en=0: req we=1 addr=0x005 wdata=0xDEADBEEF @c0 -> c1 gnt=1,
//     hold=1, mem_we=1, mem_addr=0x005, cpu_stall=1; c2 IDLE, mem[5]=0xDEADBEEF.
//  T3 host read mem[0x010]=0x12345678 @c0 -> gnt c1, stall c1-c2, rvalid c3 rdata 0x12345678.
//  T4 starvation, MAX_WAIT=8, cpu_en=1 always, host_req @c0 -> gnt exactly c9,
//     CPU accesses c0-c8 reach memory unchanged.
//  T5 back-to-back host writes, cpu_en=0, req held -> gnt c1,c3,c5; cpu_stall 1,0,1,0.
//  T6 rst=0 during H_WAIT -> no rvalid ever, next read after reset completes normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Shares one data-memory port between the CPU datapath and a host
//            loader/debugger; CPU has priority, a wait counter forces host service.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    H_ACC  = 2'd1,
    H_WAIT = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                grant_d;
  logic [ADDR_W-1:0]   h_addr_q;
  logic                h_we_q;
  logic [DATA_W-1:0]   h_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Host wins in IDLE when the CPU is idle or the host has waited long enough.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    grant_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_req && (!cpu_en || wait_cnt_q == MAX_WAIT_C)) begin
          state_d    = H_ACC;
          wait_cnt_d = '0;
          grant_d    = 1'b1;
        end else if (!host_req) begin
          wait_cnt_d = '0;
        end else if (cpu_en && wait_cnt_q != MAX_WAIT_C) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      H_ACC:   state_d = h_we_q ? IDLE : H_WAIT;
      H_WAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_addr_q  <= '0;
      h_we_q    <= 1'b0;
      h_wdata_q <= '0;
    end else if (grant_d) begin
      h_addr_q  <= host_addr;
      h_we_q    <= host_we;
      h_wdata_q <= host_wdata;
    end
  end

  // Memory output lags the address by one cycle, so capture at the end of H_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= (state_q == H_WAIT);
      if (state_q == H_WAIT) begin
        rdata_q <= mem_dout;
      end
    end
  end

  // IDLE outputs are gated by reset so nothing reaches memory while in reset.
  always_comb begin
    cpu_stall   = 1'b0;
    host_gnt    = 1'b0;
    hold        = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_din     = '0;
    host_rdata  = rdata_q;
    host_rvalid = rvalid_q;
    case (state_q)
      IDLE: begin
        if (rst) begin
          mem_addr = cpu_addr;
          mem_din  = cpu_wdata;
          mem_we   = cpu_en & cpu_we;
        end
      end
      H_ACC: begin
        host_gnt  = 1'b1;
        hold      = 1'b1;
        cpu_stall = 1'b1;
        mem_addr  = h_addr_q;
        mem_din   = h_wdata_q;
        mem_we    = h_we_q;
      end
      H_WAIT: begin
        hold      = 1'b1;
        cpu_stall = 1'b1;
        mem_addr  = h_addr_q;
        mem_din   = h_wdata_q;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Directed self-checking bench for data_mem_arbiter with a small
//            synchronous-read memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        host_req, host_we;
  logic [9:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        hold;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:1023];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  data_mem_arbiter #(
    .ADDR_W(10), .DATA_W(32), .MAX_WAIT(8), .WAIT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .hold(hold), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a host read in the current cycle; expects gnt c1, stall c1-c2, rvalid c3.
  task automatic host_read(input logic [9:0] a, input logic [31:0] exp);
    host_req = 1'b1; host_we = 1'b0; host_addr = a; cpu_en = 1'b0;
    cyc();
    check("rd_gnt", {31'd0, host_gnt}, 32'd1);
    host_req = 1'b0;
    cyc();
    check("rd_wait_stall", {31'd0, cpu_stall}, 32'd1);
    check("rd_wait_we", {31'd0, mem_we}, 32'd0);
    cyc();
    check("rd_rvalid", {31'd0, host_rvalid}, 32'd1);
    check("rd_rdata", host_rdata, exp);
    check("rd_unstall", {31'd0, cpu_stall}, 32'd0);
    cyc();
    check("rd_rvalid_pulse", {31'd0, host_rvalid}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0; cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3; cpu_wdata = 32'h1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h7; host_wdata = 32'h2;

    // T1: reset with traffic on the inputs
    cyc(); cyc();
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_hold", {31'd0, hold}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_gnt", {31'd0, host_gnt}, 32'd0);
    check("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("rst_rdata", host_rdata, 32'd0);
    cpu_en = 1'b0; cpu_we = 1'b0; host_req = 1'b0;
    rst = 1'b1;
    cyc();

    // T2: host write with CPU idle
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h005; host_wdata = 32'hDEADBEEF;
    #1;
    check("t2_c0_gnt", {31'd0, host_gnt}, 32'd0);
    cyc();
    check("t2_gnt", {31'd0, host_gnt}, 32'd1);
    check("t2_hold", {31'd0, hold}, 32'd1);
    check("t2_mem_we", {31'd0, mem_we}, 32'd1);
    check("t2_mem_addr", {22'd0, mem_addr}, 32'h005);
    check("t2_mem_din", mem_din, 32'hDEADBEEF);
    check("t2_stall", {31'd0, cpu_stall}, 32'd1);
    host_req = 1'b0;
    cyc();
    check("t2_idle_stall", {31'd0, cpu_stall}, 32'd0);
    check("t2_idle_gnt", {31'd0, host_gnt}, 32'd0);
    check("t2_mem5", mem[5], 32'hDEADBEEF);

    // T3: write 0x12345678 to 0x010, then read it back
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h010; host_wdata = 32'h12345678;
    cyc();
    check("t3_wr_gnt", {31'd0, host_gnt}, 32'd1);
    host_req = 1'b0;
    cyc();
    host_read(10'h010, 32'h12345678);
    check("t3_rdata_held", host_rdata, 32'h12345678);

    // T4: starvation; CPU accesses c0-c8 pass through, forced grant at c9
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FF; host_wdata = 32'hCAFEF00D;
    cpu_en = 1'b1; cpu_we = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cpu_addr = 10'h100 + 10'(i); cpu_wdata = 32'hA000_0000 + i;
      #1;
      check("t4_no_gnt", {31'd0, host_gnt}, 32'd0);
      check("t4_cpu_addr", {22'd0, mem_addr}, 32'h100 + i);
      check("t4_cpu_we", {31'd0, mem_we}, 32'd1);
      cyc();
    end
    check("t4_gnt_c9", {31'd0, host_gnt}, 32'd1);
    check("t4_host_addr", {22'd0, mem_addr}, 32'h3FF);
    check("t4_stall", {31'd0, cpu_stall}, 32'd1);
    host_req = 1'b0;
    cyc();
    check("t4_unstall", {31'd0, cpu_stall}, 32'd0);
    check("t4_mem_cpu", mem[10'h108], 32'hA000_0008);
    check("t4_mem_host", mem[10'h3FF], 32'hCAFEF00D);

    // Request dropped before grant clears the wait count
    cpu_addr = 10'h200; cpu_wdata = 32'h0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h020; host_wdata = 32'h5555AAAA;
    cyc(); cyc(); cyc();
    host_req = 1'b0;
    cyc();
    check("drop_no_gnt", {31'd0, host_gnt}, 32'd0);
    host_req = 1'b1;
    n = 0;
    while (!host_gnt && n < 20) begin
      cyc();
      n++;
    end
    check("drop_regrant_cycles", n, 32'd9);
    host_req = 1'b0;
    cyc();

    // T5: back-to-back host writes with request held
    cpu_en = 1'b0; cpu_we = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h030; host_wdata = 32'h0BADF00D;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check("t5_gnt", {31'd0, host_gnt}, {31'd0, k[0]});
      check("t5_stall", {31'd0, cpu_stall}, {31'd0, k[0]});
    end
    host_req = 1'b0;
    cyc();
    check("t5_mem", mem[10'h030], 32'h0BADF00D);

    // T6: reset during H_WAIT aborts the read
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h3FF;
    cyc();
    host_req = 1'b0;
    cyc();
    check("t6_in_wait", {31'd0, hold}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_hold", {31'd0, hold}, 32'd0);
    check("t6_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("t6_rst_rdata", host_rdata, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t6_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    end
    rst = 1'b1;
    cyc();
    check("t6_post_rvalid", {31'd0, host_rvalid}, 32'd0);
    host_read(10'h3FF, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
